// File: rtl/sn76489_pkg.sv
// Shared constants for the SN76489AN model: volume curve, register address map,
// and the tone frequency width.
package sn76489_pkg;

    localparam int FREQ_W = 10;

    // Output amplitude per attenuation step (2 dB each); step 15 is mute.
    localparam logic [0:15][7:0] VOL_TABLE = '{
        8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
        8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
    };

    // Latch-byte address field d[6:4]: {channel, register type}.
    typedef enum logic [2:0] {
        ADDR_TONE0_FREQ = 3'b000,
        ADDR_TONE0_ATTN = 3'b001,
        ADDR_TONE1_FREQ = 3'b010,
        ADDR_TONE1_ATTN = 3'b011,
        ADDR_TONE2_FREQ = 3'b100,
        ADDR_TONE2_ATTN = 3'b101,
        ADDR_NOISE_CTRL = 3'b110,
        ADDR_NOISE_ATTN = 3'b111
    } reg_addr_e;

    function automatic logic [2:0] tone_freq_addr(input logic [1:0] ch);
        return {ch, 1'b0};
    endfunction

    function automatic logic [2:0] tone_attn_addr(input logic [1:0] ch);
        return {ch, 1'b1};
    endfunction

endpackage

// File: rtl/sn76489_attenuator.sv
// Maps a 4-bit attenuation and the current square-wave level to an unsigned
// 8-bit amplitude sample. Shared by the tone and noise channels.
module sn76489_attenuator
    import sn76489_pkg::*;
(
    input  logic       level,
    input  logic [3:0] attn,
    output logic [7:0] ampl
);

    assign ampl = level ? VOL_TABLE[attn] : 8'd0;

endmodule

// File: rtl/sn76489_tone.sv
// One square-wave tone channel: decodes its own frequency/attenuation
// registers from the byte-wide write bus and divides the tick into a tone.
module sn76489_tone
    import sn76489_pkg::*;
#(
    parameter int channel_g = 0
) (
    input  logic       clock_i,
    input  logic       res_n_i,
    input  logic       clock_en_i,
    input  logic       clk_div_en_i,
    input  logic       wr_i,
    input  logic [7:0] d_i,
    output logic       tone_o,
    output logic       tone_pulse_o,
    output logic [7:0] ampl_o
);

    localparam logic [2:0] FREQ_ADDR = tone_freq_addr(2'(channel_g));
    localparam logic [2:0] ATTN_ADDR = tone_attn_addr(2'(channel_g));

    logic [FREQ_W-1:0] freq_q;
    logic [FREQ_W-1:0] cnt_q;
    logic [3:0]        attn_q;
    logic              tone_q;
    logic              tone_pulse_q;
    logic              lat_freq_q;
    logic              lat_attn_q;
    logic              tick;
    logic              reload;

    assign tick   = clock_en_i & clk_div_en_i;
    assign reload = tick && (cnt_q <= FREQ_W'(1));

    // Register write decode; runs on every strobe regardless of clock_en_i.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            freq_q     <= '0;
            attn_q     <= 4'hF;
            lat_freq_q <= 1'b0;
            lat_attn_q <= 1'b0;
        end else if (wr_i) begin
            // NOTE: non-blocking assignments let the counter block below see
            // the pre-write freq_q when a write and a reload share a cycle.
            if (d_i[7]) begin
                if (d_i[6:4] == FREQ_ADDR) begin
                    freq_q[3:0] <= d_i[3:0];
                    lat_freq_q  <= 1'b1;
                    lat_attn_q  <= 1'b0;
                end else if (d_i[6:4] == ATTN_ADDR) begin
                    attn_q     <= d_i[3:0];
                    lat_attn_q <= 1'b1;
                    lat_freq_q <= 1'b0;
                end else begin
                    lat_freq_q <= 1'b0;
                    lat_attn_q <= 1'b0;
                end
            end else if (lat_freq_q) begin
                freq_q[9:4] <= d_i[5:0];
            end else if (lat_attn_q) begin
                attn_q <= d_i[3:0];
            end
        end
    end

    // A count of 0 or 1 reloads, so freq_q = 0 behaves as a half-period of 1.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            cnt_q        <= '0;
            tone_q       <= 1'b0;
            tone_pulse_q <= 1'b0;
        end else begin
            tone_pulse_q <= reload;
            if (reload) begin
                cnt_q  <= freq_q;
                tone_q <= ~tone_q;
            end else if (tick) begin
                cnt_q <= cnt_q - FREQ_W'(1);
            end
        end
    end

    assign tone_o       = tone_q;
    assign tone_pulse_o = tone_pulse_q;

    sn76489_attenuator u_attenuator (
        .level (tone_q),
        .attn  (attn_q),
        .ampl  (ampl_o)
    );

endmodule
